truth_table_sweeper: RTL and testbench

- Synthesisable, parametrised exhaustive-stimulus engine for N-input combinational blocks.
- On `start`, drives every input combination 0..2^N_IN-1 onto `stim` and holds each for HOLD_CYCLES clocks.
- Samples the DUT response and compares it against a packed golden truth table, reporting error count, first failing index and pass/fail.
- Replaces hand-written per-vector stimulus sequences with one reusable hardware sweeper for lab combinational designs.

---
 rtl/tts_pkg.sv | 17 +
 rtl/tts_hold_timer.sv | 46 ++++
 rtl/truth_table_sweeper.sv | 161 ++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tts_pkg;

   // Sweeper control states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } tts_state_e;

   // Number of input vectors in an exhaustive sweep of n_in inputs
   function automatic int unsigned tts_vec_count(input int unsigned n_in);
      return 32'd1 << n_in;
   endfunction

endpackage : tts_pkg

// File: rtl/tts_hold_timer.sv
// Hold timer: counts 0..HOLD_CYCLES-1 and flags the terminal count.
// hold_tc is registered and is already high on the cycle the count sits at
// HOLD_CYCLES-1, so a hold of one cycle works without special casing.
module tts_hold_timer #(
   parameter int unsigned HOLD_CYCLES = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic en_i,
   output logic hold_tc
);

   localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] TC_VAL = CW'(HOLD_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tc_q, tc_d;

   // Next count: load restarts at zero, enable advances until terminal count
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = tc_q;
      if (load_i) begin
         cnt_d = '0;
         tc_d  = (TC_VAL == '0);
      end else if (en_i && !tc_q) begin
         cnt_d = cnt_q + CW'(1);
         tc_d  = (cnt_d == TC_VAL);
      end
   end

   // Count and terminal-count registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tc_q  <= (TC_VAL == '0);
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
      end
   end

   assign hold_tc = tc_q;

endmodule : tts_hold_timer

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector onto stim, holds
// it HOLD_CYCLES clocks, samples resp and scores it against a packed golden
// table. All outputs are registered.
// Build option: define TTS_STOP_ON_ERR_EN to stop at the first mismatch with
// stim frozen on the failing vector.
module truth_table_sweeper
   import tts_pkg::*;
#(
   parameter int unsigned N_IN        = 4,
   parameter int unsigned N_OUT       = 2,
   parameter int unsigned HOLD_CYCLES = 20
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [(2**N_IN)*N_OUT-1:0]    golden,
   input  logic [N_OUT-1:0]              resp,
   output logic [N_IN-1:0]               stim,
   output logic                          busy,
   output logic                          done,
   output logic                          pass,
   output logic [N_IN:0]                 err_count,
   output logic [N_IN-1:0]               first_err_idx,
   output logic                          err_seen
);

   localparam int unsigned NVEC = tts_vec_count(N_IN);
   localparam int unsigned EW   = N_IN + 1;

   tts_state_e       state_q, state_d;
   logic [N_IN-1:0]  idx_q, idx_d;
   logic [N_IN-1:0]  stim_q, stim_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [EW-1:0]    err_count_q, err_count_d;
   logic [N_IN-1:0]  first_q, first_d;
   logic             err_seen_q, err_seen_d;

   logic             tmr_load_c, tmr_en_c, hold_tc;
   logic             mismatch_c, to_done_c;
   logic [N_OUT-1:0] gold_arr [NVEC];

   // Unpack the golden table into one entry per vector
   for (genvar g = 0; g < NVEC; g++) begin : g_gold
      assign gold_arr[g] = golden[g*N_OUT +: N_OUT];
   end

   assign mismatch_c = (resp != gold_arr[idx_q]);

   tts_hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (tmr_load_c),
      .en_i    (tmr_en_c),
      .hold_tc (hold_tc)
   );

   // Next-state, index and scoreboard logic
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      stim_d      = stim_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      err_count_d = err_count_q;
      first_d     = first_q;
      err_seen_d  = err_seen_q;
      tmr_load_c  = 1'b0;
      tmr_en_c    = 1'b0;
      to_done_c   = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = DRIVE;
               idx_d       = '0;
               stim_d      = '0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               err_count_d = '0;
               first_d     = '0;
               err_seen_d  = 1'b0;
               tmr_load_c  = 1'b1;
            end
         end
         DRIVE: begin
            if (hold_tc) begin
               state_d = SAMPLE;
            end else begin
               tmr_en_c = 1'b1;
            end
         end
         SAMPLE: begin
            if (mismatch_c) begin
               err_count_d = err_count_q + EW'(1);
               if (!err_seen_q) begin
                  first_d    = idx_q;
                  err_seen_d = 1'b1;
               end
            end
            to_done_c = (idx_q == '1);
`ifdef TTS_STOP_ON_ERR_EN
            if (mismatch_c) begin
               to_done_c = 1'b1;
            end
`endif
            if (to_done_c) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_count_d == '0);
            end else begin
               state_d    = DRIVE;
               idx_d      = idx_q + N_IN'(1);
               stim_d     = idx_q + N_IN'(1);
               tmr_load_c = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         stim_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_count_q <= '0;
         first_q     <= '0;
         err_seen_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         stim_q      <= stim_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_count_q <= err_count_d;
         first_q     <= first_d;
         err_seen_q  <= err_seen_d;
      end
   end

   assign stim          = stim_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_count     = err_count_q;
   assign first_err_idx = first_q;
   assign err_seen      = err_seen_q;

endmodule : truth_table_sweeper

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a 4-input/2-output instance with a hold of 4
// and a 1-input/1-output instance with a hold of 1, both scored against a
// vector-level reference model.
module tb_truth_table_sweeper;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        rst_n;

   // Main instance
   logic        start_m;
   logic [31:0] golden_m;
   logic [1:0]  resp_m;
   logic [3:0]  stim_m;
   logic        busy_m, done_m, pass_m, err_seen_m;
   logic [4:0]  err_count_m;
   logic [3:0]  first_m;

   // Corner instance
   logic        start_s;
   logic [1:0]  golden_s;
   logic [0:0]  resp_s;
   logic [0:0]  stim_s;
   logic        busy_s, done_s, pass_s, err_seen_s;
   logic [1:0]  err_count_s;
   logic [0:0]  first_s;

   logic [1:0]  exp_tab [16];
   logic [1:0]  xor_tab [16];

   int n_checks = 0;
   int n_fail   = 0;

   int exp_errs, exp_first, exp_last, exp_cycles;
   bit exp_pass;

   always #5 clk = ~clk;

   truth_table_sweeper #(.N_IN(4), .N_OUT(2), .HOLD_CYCLES(HOLD)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_m), .golden(golden_m), .resp(resp_m),
      .stim(stim_m), .busy(busy_m), .done(done_m), .pass(pass_m),
      .err_count(err_count_m), .first_err_idx(first_m), .err_seen(err_seen_m));

   truth_table_sweeper #(.N_IN(1), .N_OUT(1), .HOLD_CYCLES(1)) u_small (
      .clk(clk), .rst_n(rst_n), .start(start_s), .golden(golden_s), .resp(resp_s),
      .stim(stim_s), .busy(busy_s), .done(done_s), .pass(pass_s),
      .err_count(err_count_s), .first_err_idx(first_s), .err_seen(err_seen_s));

   // Lab DUT: inputs a,b,c,d with a as the MSB of stim
   function automatic logic [1:0] ref_fn(input logic [3:0] v);
      logic a, b, c, d;
      {a, b, c, d} = v;
      return {(a & b) | (c & d), a ^ b ^ c ^ d};
   endfunction

   // Simulated DUT response, optionally with per-vector faults
   always_comb resp_m = ref_fn(stim_m) ^ xor_tab[stim_m];
   always_comb resp_s = stim_s;

   task automatic load_golden();
      golden_m = '0;
      for (int v = 0; v < 16; v++) golden_m = golden_m | (32'(exp_tab[v]) << (2 * v));
   endtask

   // Vector-level expectation of a sweep of the main instance
   task automatic model_main();
      exp_errs = 0; exp_first = 0; exp_last = 15;
      for (int v = 0; v < 16; v++) begin
         if ((ref_fn(4'(v)) ^ xor_tab[v]) != exp_tab[v]) begin
            if (exp_errs == 0) exp_first = v;
            exp_errs++;
`ifdef TTS_STOP_ON_ERR_EN
            exp_last = v;
            break;
`endif
         end
      end
      exp_pass   = (exp_errs == 0);
      exp_cycles = (exp_last + 1) * (HOLD + 1) + 1;
   endtask

   task automatic run_main(input int restart_at, input string tag);
      int k;
      bit seq_ok;
      int bad_k;
      logic [3:0] bad_stim, want;
      model_main();
      @(negedge clk);
      start_m = 1'b1;
      k = 0; seq_ok = 1'b1; bad_k = 0; bad_stim = '0;
      while (k < 2000) begin
         @(posedge clk); #1;
         k++;
         start_m = (k == restart_at);
         if (k == 1) begin
            n_checks++;
            if ({err_count_m, first_m, err_seen_m, pass_m, done_m, busy_m} !== {5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
               n_fail++;
               $display("FAIL %s_clear_on_start: err=%0d first=%0d seen=%0d pass=%0d done=%0d busy=%0d want 0,0,0,0,0,1",
                        tag, err_count_m, first_m, err_seen_m, pass_m, done_m, busy_m);
            end
         end
         if (done_m) break;
         want = 4'((k - 1) / (HOLD + 1));
         if (seq_ok && stim_m !== want) begin
            seq_ok = 1'b0; bad_k = k; bad_stim = stim_m;
         end
      end
      start_m = 1'b0;
      n_checks++;
      if (k != exp_cycles) begin
         n_fail++; $display("FAIL %s_latency: got %0d cycles want %0d", tag, k, exp_cycles);
      end
      n_checks++;
      if (!seq_ok) begin
         n_fail++; $display("FAIL %s_stim_seq: cycle %0d stim=%0d want %0d", tag, bad_k, bad_stim, (bad_k - 1) / (HOLD + 1));
      end
      n_checks++;
      if (err_count_m !== 5'(exp_errs)) begin
         n_fail++; $display("FAIL %s_err_count: got %0d want %0d", tag, err_count_m, exp_errs);
      end
      n_checks++;
      if (first_m !== 4'(exp_first)) begin
         n_fail++; $display("FAIL %s_first_err_idx: got %0d want %0d", tag, first_m, exp_first);
      end
      n_checks++;
      if ({pass_m, err_seen_m} !== {exp_pass, exp_errs != 0}) begin
         n_fail++; $display("FAIL %s_pass_seen: got pass=%0d seen=%0d want pass=%0d seen=%0d", tag, pass_m, err_seen_m, exp_pass, exp_errs != 0);
      end
      n_checks++;
      if ({stim_m, busy_m} !== {4'(exp_last), 1'b0}) begin
         n_fail++; $display("FAIL %s_final_stim: got stim=%0d busy=%0d want stim=%0d busy=0", tag, stim_m, busy_m, exp_last);
      end
   endtask

   task automatic set_correct();
      for (int v = 0; v < 16; v++) begin
         exp_tab[v] = ref_fn(4'(v));
         xor_tab[v] = 2'b00;
      end
      load_golden();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start_m = 1'b0; start_s = 1'b0; golden_s = 2'b10;
      set_correct();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({stim_m, busy_m, done_m, pass_m, err_count_m, first_m, err_seen_m} !== '0) begin
         n_fail++; $display("FAIL reset_main: got stim=%0d busy=%0d done=%0d pass=%0d err=%0d first=%0d seen=%0d want all 0",
                             stim_m, busy_m, done_m, pass_m, err_count_m, first_m, err_seen_m);
      end
      n_checks++;
      if ({stim_s, busy_s, done_s, pass_s, err_count_s, first_s, err_seen_s} !== '0) begin
         n_fail++; $display("FAIL reset_small: got stim=%0d busy=%0d done=%0d pass=%0d err=%0d want all 0",
                             stim_s, busy_s, done_s, pass_s, err_count_s);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_correct_dut();
      set_correct();
      run_main(0, "correct");
   endtask

   task automatic test_single_fault();
      set_correct();
      exp_tab[9] = ~ref_fn(4'd9);
      load_golden();
      run_main(0, "single_fault");
   endtask

   task automatic test_back_to_back();
      set_correct();
      for (int v = 0; v < 16; v++) xor_tab[v] = 2'b11;
      run_main(12, "all_fault");
      for (int v = 0; v < 16; v++) xor_tab[v] = 2'b00;
      run_main(0, "rerun");
   endtask

   task automatic test_reset_mid();
      set_correct();
      for (int v = 0; v < 16; v++) xor_tab[v] = 2'b01;
      @(negedge clk);
      start_m = 1'b1;
      @(posedge clk); #1;
      start_m = 1'b0;
      repeat (29) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({stim_m, busy_m, done_m, pass_m, err_count_m, first_m, err_seen_m} !== '0) begin
         n_fail++; $display("FAIL reset_mid_async: got stim=%0d busy=%0d done=%0d err=%0d first=%0d seen=%0d want all 0",
                             stim_m, busy_m, done_m, err_count_m, first_m, err_seen_m);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int v = 0; v < 16; v++) xor_tab[v] = 2'b00;
      run_main(0, "after_reset");
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         for (int v = 0; v < 16; v++) begin
            exp_tab[v] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : ref_fn(4'(v));
            xor_tab[v] = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
         end
         load_golden();
         run_main(0, $sformatf("random%0d", it));
      end
   endtask

   task automatic test_stop_on_err();
      set_correct();
      exp_tab[5]  = ~ref_fn(4'd5);
      exp_tab[12] = ref_fn(4'd12) ^ 2'b01;
      load_golden();
      run_main(0, "two_faults");
   endtask

   task automatic test_corner();
      logic [1:0] gtab [2];
      gtab[0] = 2'b10;
      gtab[1] = 2'b00;
      for (int t = 0; t < 2; t++) begin
         int k, e_err, e_first, e_last, e_cyc;
         logic [3:0] seq;
         logic [1:0] g;
         g = gtab[t];
         e_err = 0; e_first = 0; e_last = 1;
         for (int v = 0; v < 2; v++) begin
            if ((v == 0 && g[0] != 1'b0) || (v == 1 && g[1] != 1'b1)) begin
               if (e_err == 0) e_first = v;
               e_err++;
`ifdef TTS_STOP_ON_ERR_EN
               e_last = v;
               break;
`endif
            end
         end
         e_cyc = (e_last + 1) * 2 + 1;
         golden_s = g;
         @(negedge clk);
         start_s = 1'b1;
         k = 0; seq = '0;
         while (k < 200) begin
            @(posedge clk); #1;
            k++;
            start_s = 1'b0;
            if (done_s) break;
            if (k <= 4) seq = {stim_s[0], seq[3:1]};
         end
         n_checks++;
         if (k != e_cyc) begin
            n_fail++; $display("FAIL corner%0d_latency: got %0d want %0d", t, k, e_cyc);
         end
         if (e_last == 1) begin
            n_checks++;
            if (seq !== 4'b1100) begin
               n_fail++; $display("FAIL corner%0d_stim_seq: got %b want 1100 (oldest in lsb)", t, seq);
            end
         end
         n_checks++;
         if ({err_count_s, first_s, pass_s, stim_s} !== {2'(e_err), 1'(e_first), e_err == 0, 1'(e_last)}) begin
            n_fail++; $display("FAIL corner%0d_result: got err=%0d first=%0d pass=%0d stim=%0d want %0d %0d %0d %0d",
                                t, err_count_s, first_s, pass_s, stim_s, e_err, e_first, e_err == 0, e_last);
         end
      end
   endtask

   initial begin
      test_reset();
      test_correct_dut();
      test_single_fault();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_stop_on_err();
      test_corner();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_truth_table_sweeper
